// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM states and helpers for the
// iterative multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_UMULL = 4'b0110;
  localparam logic [3:0] OP_SMULL = 4'b1000;
  localparam logic [3:0] OP_DIV   = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic is_legal(
    input logic [3:0] op
  );
    return op inside {OP_MUL, OP_UMULL, OP_SMULL, OP_DIV};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration on the {acc,q} pair: shift-add
// multiply step or restoring shift-subtract step.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum  = {1'b0, acc} + {1'b0, (q[0] ? m : '0)};
    rem  = {acc, q[WIDTH-1]};
    ge   = rem >= {1'b0, m};
    // a successful trial leaves rem-m < m, so W bits suffice
    diff = rem[WIDTH-1:0] - m;
    if (is_div) begin
      acc_nxt = ge ? diff : rem[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], ge};
    end else begin
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/UMULL/SMULL/DIV unit with
// start/busy/done handshake and N/Z flags.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z,
  output logic             div_zero,
  output logic             illegal_op
);

  import muldiv_unit_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             neg;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] prod;
  logic               wide;
  logic               fn;
  logic               fz;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div (op_q == OP_DIV),
    .acc    (acc),
    .q      (q),
    .m      (m),
    .acc_nxt(acc_nxt),
    .q_nxt  (q_nxt)
  );

  always_comb begin
    raw  = {acc, q};
    prod = (op_q == OP_SMULL && neg) ? -raw : raw;
    wide = op_q inside {OP_UMULL, OP_SMULL};
    fn   = wide ? prod[2*WIDTH-1] : prod[WIDTH-1];
    fz   = wide ? (prod == '0)
                : (prod[WIDTH-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      acc        <= '0;
      q          <= '0;
      m          <= '0;
      neg        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result_lo  <= '0;
      result_hi  <= '0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
      div_zero   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // done high means we just left DONE: drop start
          if (start && !done) begin
            div_zero   <= 1'b0;
            illegal_op <= 1'b0;
            if (!is_legal(op)) begin
              illegal_op <= 1'b1;
              result_lo  <= '0;
              result_hi  <= '0;
              flag_n     <= 1'b0;
              flag_z     <= 1'b1;
              state      <= S_DONE;
            end else begin
              op_q <= op;
              cnt  <= '0;
              busy <= 1'b1;
              acc  <= '0;
              q    <= a;
              m    <= b;
              neg  <= 1'b0;
              if (op == OP_SMULL) begin
                q   <= a[WIDTH-1] ? -a : a;
                m   <= b[WIDTH-1] ? -b : b;
                neg <= a[WIDTH-1] ^ b[WIDTH-1];
              end
              if (op == OP_DIV && b == '0) begin
                // FIX passes {acc,q} straight out
                acc      <= a;
                q        <= '1;
                div_zero <= 1'b1;
                state    <= S_FIX;
              end else begin
                state <= S_RUN;
              end
            end
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result_hi <= prod[2*WIDTH-1:WIDTH];
          result_lo <= prod[WIDTH-1:0];
          flag_n    <= fn;
          flag_z    <= fz;
          busy      <= 1'b0;
          state     <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit
// against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [3:0] MUL   = 4'b0100;
  localparam logic [3:0] UMULL = 4'b0110;
  localparam logic [3:0] SMULL = 4'b1000;
  localparam logic [3:0] DIV   = 4'b0111;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         flag_n;
  logic         flag_z;
  logic         div_zero;
  logic         illegal_op;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .div_zero  (div_zero),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [3:0] o);
    return o == MUL || o == UMULL ||
           o == SMULL || o == DIV;
  endfunction

  task automatic model(
    input  logic [3:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [63:0] r,
    output logic        n,
    output logic        z,
    output logic        dz,
    output logic        il,
    output int          lat
  );
    longint sx;
    longint sy;
    dz  = 1'b0;
    il  = 1'b0;
    lat = W + 2;
    sx  = longint'(int'(x));
    sy  = longint'(int'(y));
    case (o)
      MUL, UMULL: r = 64'(x) * 64'(y);
      SMULL:      r = 64'(sx * sy);
      DIV: begin
        if (y == 0) begin
          r   = {x, 32'hFFFF_FFFF};
          dz  = 1'b1;
          lat = 2;
        end else begin
          r = {x % y, x / y};
        end
      end
      default: begin
        r   = 64'd0;
        il  = 1'b1;
        lat = 1;
      end
    endcase
    if (il) begin
      n = 1'b0;
      z = 1'b1;
    end else if (o == UMULL || o == SMULL) begin
      n = r[63];
      z = (r == 64'd0);
    end else begin
      n = r[31];
      z = (r[31:0] == 32'd0);
    end
  endtask

  task automatic run(
    input logic [3:0]  o,
    input logic [31:0] x,
    input logic [31:0] y,
    input string       tag
  );
    logic [63:0] r;
    logic        n, z, dz, il;
    int          lat;
    int          cyc;
    model(o, x, y, r, n, z, dz, il, lat);
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, ":busy1"}, 64'(busy), 64'(!il));
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, ":lat"}, 64'(cyc), 64'(lat));
    check({tag, ":res"}, {result_hi, result_lo}, r);
    check({tag, ":n"}, 64'(flag_n), 64'(n));
    check({tag, ":z"}, 64'(flag_z), 64'(z));
    check({tag, ":dz"}, 64'(div_zero), 64'(dz));
    check({tag, ":il"}, 64'(illegal_op), 64'(il));
    check({tag, ":busy0"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, ":pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [63:0] r0;
    logic        n0, z0, dz0, il0;
    int          lat0;
    int          dones;
    int          dcyc;
    int          late_busy;
    logic [63:0] res;
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    int          k;

    reset = 1'b1;
    start = 1'b0;
    op    = 4'd0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:done", 64'(done), 64'd0);
    check("rst:res", {result_hi, result_lo}, 64'd0);
    check("rst:flags",
          {60'd0, flag_n, flag_z, div_zero, illegal_op},
          64'd0);
    @(negedge clk);
    reset = 1'b0;

    run(UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umull_max");
    run(SMULL, 32'hFFFF_FFFE, 32'd3, "smull_neg");
    run(SMULL, 32'h8000_0000, 32'h8000_0000, "smull_min");
    run(DIV, 32'd100, 32'd7, "div");
    run(DIV, 32'd5, 32'd0, "div0");
    run(MUL, 32'd0, 32'h1234, "mul0");
    run(4'b0011, 32'd9, 32'd9, "ill");
    run(MUL, 32'hFFFF_FFFF, 32'd2, "mul_neg");

    // re-pulsed start during a busy UMULL and on the done cycle
    model(UMULL, 32'h1234_5678, 32'h9ABC_DEF0,
          r0, n0, z0, dz0, il0, lat0);
    @(negedge clk);
    op    = UMULL;
    a     = 32'h1234_5678;
    b     = 32'h9ABC_DEF0;
    start = 1'b1;
    @(posedge clk);
    #1;
    dones     = 0;
    dcyc      = 0;
    late_busy = 0;
    res       = '0;
    for (int i = 1; i <= 50; i++) begin
      start = (i == 5 || i == 20 || i == 35);
      if (start) begin
        op = UMULL;
        a  = $urandom;
        b  = $urandom;
      end
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        dcyc = i;
        res  = {result_hi, result_lo};
      end
      if (i > 35 && busy) late_busy++;
    end
    start = 1'b0;
    check("rep:dones", 64'(dones), 64'd1);
    check("rep:lat", 64'(dcyc), 64'(lat0));
    check("rep:res", res, r0);
    check("rep:held", {result_hi, result_lo}, r0);
    check("rep:nobusy", 64'(late_busy), 64'd0);

    // reset in the middle of a DIV
    @(negedge clk);
    op    = DIV;
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid:busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid:busy0", 64'(busy), 64'd0);
    check("mid:res", {result_hi, result_lo}, 64'd0);
    check("mid:done", 64'(done), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    check("mid:quiet", 64'(dones), 64'd0);
    run(DIV, 32'd1000, 32'd3, "after_rst");

    for (int t = 0; t < 40; t++) begin
      k  = $urandom_range(0, 9);
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      case (k)
        0, 1: ro = MUL;
        2, 3: ro = UMULL;
        4, 5: ro = SMULL;
        6, 7: ro = DIV;
        8: begin
          ro = DIV;
          rb = 32'd0;
        end
        default: begin
          ro = 4'($urandom_range(0, 15));
          while (legal(ro)) ro = 4'($urandom_range(0, 15));
        end
      endcase
      if (t % 7 == 3) ra = 32'd0;
      run(ro, ra, rb, $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
